// File: rtl/stoplight_controller_pkg.sv
// Shared types and lamp encodings for the stoplight controller.
// Phase encodings double as the debug `phase` output.
package stoplight_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    WALK = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    AR2  = 3'd6
  } state_t;

  // Lamp vectors are {red, yellow, green}, one-hot.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef struct packed {
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
  } lamps_t;

  function automatic lamps_t lamps_for(state_t s);
    lamps_t l;
    l.ns_light = LIGHT_RED;
    l.ew_light = LIGHT_RED;
    l.walk     = 1'b0;
    case (s)
      NS_G:    l.ns_light = LIGHT_GRN;
      NS_Y:    l.ns_light = LIGHT_YEL;
      EW_G:    l.ew_light = LIGHT_GRN;
      EW_Y:    l.ew_light = LIGHT_YEL;
      WALK:    l.walk     = 1'b1;
      default: l.ns_light = LIGHT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/stoplight_controller_if.sv
// Signal bundle between the tick source / sensors and the lamp drivers.
// The master side drives strobes and sensors; the slave (controller) drives lamps.
interface stoplight_controller_if;

   logic       tick;
   logic       en;
   logic       ped_req;
   logic       ew_car;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic       ped_pending;
   logic [2:0] phase;

   modport master (
      output tick, en, ped_req, ew_car,
      input  ns_light, ew_light, walk, ped_pending, phase
   );

   modport slave (
      input  tick, en, ped_req, ew_car,
      output ns_light, ew_light, walk, ped_pending, phase
   );

endinterface

// File: rtl/stoplight_controller_phase_timer.sv
// Saturating phase timer: counts enable strobes up to limit-1 and holds there.
// `done` flags an enabled strobe that lands on the final count.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] last;

   assign last = limit - CNT_W'(1);

   // Clear dominates so the new phase never inherits a coincident tick.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q < last)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = enable && (count_q == last);

endmodule

// File: rtl/stoplight_controller.sv
// Moore sequencer for an NS/EW intersection with a pedestrian phase.
// NS green is the resting phase; it is left only on EW demand or a latched walk request.
module stoplight_controller
   import stoplight_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int GREEN_TICKS  = 20,
   parameter int YELLOW_TICKS = 4,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 10
) (
   input logic                    clk,
   input logic                    rst,
   stoplight_controller_if.slave  bus
);

   localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_TICKS);
   localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_TICKS);
   localparam logic [CNT_W-1:0] ALLRED_LIM = CNT_W'(ALLRED_TICKS);
   localparam logic [CNT_W-1:0] WALK_LIM   = CNT_W'(WALK_TICKS);

   state_t           state_q;
   state_t           state_d;
   logic             ped_pending_q;
   logic             ped_pending_d;
   logic [CNT_W-1:0] limit;
   logic             adv;
   logic             done;
   logic             state_change;
   lamps_t           lamps;

   assign adv          = bus.tick & bus.en;
   assign state_change = (state_d != state_q);

   always_comb begin
      limit = GREEN_LIM;
      case (state_q)
         NS_G, EW_G: limit = GREEN_LIM;
         NS_Y, EW_Y: limit = YELLOW_LIM;
         AR1, AR2:   limit = ALLRED_LIM;
         WALK:       limit = WALK_LIM;
         default:    limit = GREEN_LIM;
      endcase
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_change),
      .enable (adv),
      .limit  (limit),
      .done   (done)
   );

   // NOTE: defaults are assigned first so no branch can leave state_d unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         NS_G: if (done && (bus.ew_car || ped_pending_q)) state_d = NS_Y;
         NS_Y: if (done) state_d = AR1;
         AR1:  if (done) state_d = ped_pending_q ? WALK : EW_G;
         WALK: if (done) state_d = bus.ew_car ? EW_G : NS_G;
         EW_G: if (done) state_d = EW_Y;
         EW_Y: if (done) state_d = AR2;
         AR2:  if (done) state_d = NS_G;
         default: state_d = NS_G;
      endcase
   end

   // Entering WALK serves the request, so that clear outranks a same-cycle press.
   always_comb begin
      ped_pending_d = ped_pending_q;
      if ((state_d == WALK) && (state_q != WALK)) begin
         ped_pending_d = 1'b0;
      end else if (bus.ped_req && (state_q != WALK)) begin
         ped_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= NS_G;
         ped_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
      end
   end

   assign lamps = lamps_for(state_q);

   always_comb begin
      bus.ns_light    = lamps.ns_light;
      bus.ew_light    = lamps.ew_light;
      bus.walk        = lamps.walk;
      bus.ped_pending = ped_pending_q;
      bus.phase       = state_q;
   end

endmodule

// File: tb/tb_stoplight_controller.sv
// Scoreboarded random bench: a driver feeds a phase/elapsed-tick model and queues
// expected lamps; a monitor compares them against the controller after each edge.
module tb_stoplight_controller;
  import stoplight_pkg::*;

  localparam int G_T = 4;
  localparam int Y_T = 2;
  localparam int A_T = 1;
  localparam int W_T = 3;

  typedef struct packed {
    logic [2:0] phase;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       pend;
  } exp_t;

  logic clk;
  logic rst;
  stoplight_controller_if bus ();

  stoplight_controller #(
    .CNT_W        (8),
    .GREEN_TICKS  (G_T),
    .YELLOW_TICKS (Y_T),
    .ALLRED_TICKS (A_T),
    .WALK_TICKS   (W_T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  // Reference model: current phase, ticks credited to it, latched request.
  state_t m_phase   = NS_G;
  int     m_elapsed = 0;
  bit     m_pend    = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int dwell(state_t s);
    case (s)
      NS_G, EW_G: return G_T;
      NS_Y, EW_Y: return Y_T;
      AR1, AR2:   return A_T;
      WALK:       return W_T;
      default:    return G_T;
    endcase
  endfunction

  function automatic exp_t expect_of(state_t s, bit pend);
    exp_t e;
    e.phase = s;
    e.ns    = (s == NS_G) ? 3'b001 : (s == NS_Y) ? 3'b010 : 3'b100;
    e.ew    = (s == EW_G) ? 3'b001 : (s == EW_Y) ? 3'b010 : 3'b100;
    e.walk  = (s == WALK);
    e.pend  = pend;
    return e;
  endfunction

  task automatic model_step(bit adv, bit p, bit c);
    state_t nxt = m_phase;
    if (adv) begin
      m_elapsed++;
      if (m_elapsed >= dwell(m_phase)) begin
        case (m_phase)
          NS_G:    if (c || m_pend) nxt = NS_Y;
          NS_Y:    nxt = AR1;
          AR1:     nxt = m_pend ? WALK : EW_G;
          WALK:    nxt = c ? EW_G : NS_G;
          EW_G:    nxt = EW_Y;
          EW_Y:    nxt = AR2;
          default: nxt = NS_G;
        endcase
      end
    end
    if (nxt != m_phase) m_elapsed = 0;
    if (nxt == WALK && m_phase != WALK) m_pend = 1'b0;
    else if (p && m_phase != WALK)      m_pend = 1'b1;
    m_phase = nxt;
  endtask

  // Called at a falling edge: drive, predict the post-edge state, wait one cycle.
  task automatic drive_cycle(bit t, bit e, bit p, bit c);
    bus.tick    = t;
    bus.en      = e;
    bus.ped_req = p;
    bus.ew_car  = c;
    model_step(t & e, p, c);
    sb_q.push_back(expect_of(m_phase, m_pend));
    @(negedge clk);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_ns"},    32'(bus.ns_light),    32'(3'b001));
    check({tag, "_ew"},    32'(bus.ew_light),    32'(3'b100));
    check({tag, "_walk"},  32'(bus.walk),        32'd0);
    check({tag, "_pend"},  32'(bus.ped_pending), 32'd0);
    check({tag, "_phase"}, 32'(bus.phase),       32'(NS_G));
  endtask

  task automatic run_until(state_t target, bit c, string name);
    int n = 0;
    while (m_phase != target && n < 100) begin
      drive_cycle(1'b1, 1'b1, 1'b0, c);
      n++;
    end
    check(name, 32'(bus.phase), 32'(target));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("phase",   32'(bus.phase),       32'(e.phase));
        check("ns",      32'(bus.ns_light),    32'(e.ns));
        check("ew",      32'(bus.ew_light),    32'(e.ew));
        check("walk",    32'(bus.walk),        32'(e.walk));
        check("pending", 32'(bus.ped_pending), 32'(e.pend));
        check("conflict", 32'(bus.ns_light != 3'b100 && bus.ew_light != 3'b100), 32'd0);
      end
    end
  end

  initial begin : stimulus
    rst         = 1'b1;
    bus.tick    = 1'b0;
    bus.en      = 1'b0;
    bus.ped_req = 1'b0;
    bus.ew_car  = 1'b0;
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Idle: no demand keeps NS green indefinitely.
    repeat (100) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Single pedestrian pulse walks and returns to NS green.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Continuous EW demand cycles through the full sequence.
    repeat (42) drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Freeze mid NS_Y with en low, then resume.
    run_until(NS_G, 1'b1, "reach_ns_g");
    run_until(NS_Y, 1'b1, "reach_ns_y");
    repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Sparse ticks stretch every dwell by the strobe period.
    for (int i = 0; i < 100; i++) drive_cycle(i % 5 == 0, 1'b1, 1'b0, 1'b1);

    // Async reset during EW green with a request latched.
    run_until(EW_G, 1'b1, "reach_ew_g");
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("pend_before_rst", 32'(bus.ped_pending), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    m_phase   = NS_G;
    m_elapsed = 0;
    m_pend    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Random traffic, buttons, strobes and enables.
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end

    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stoplight_controller.md
Name: stoplight_controller

Overview:
Two-way intersection sequencer (NS main road, EW side road) with a pedestrian crossing. A Moore FSM steps through the light phases. An internal phase timer counts external `tick` strobes, and each phase lasts a programmed number of ticks. NS is the default phase. The controller leaves NS green only when there is EW vehicle demand or a pending pedestrian request. Sits between the prescaler (tick source) and the lamp drivers.

Parameters:
CNT_W, 8, phase timer width; each *_TICKS value is legal in 1..2^CNT_W-1
GREEN_TICKS, 20, minimum NS green dwell and fixed EW green dwell, in ticks
YELLOW_TICKS, 4, yellow dwell for either direction
ALLRED_TICKS, 2, all-red clearance dwell
WALK_TICKS, 10, pedestrian walk dwell

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timing strobe; phase timer advances only when tick=1 and en=1
en  in  1  run enable; 0 freezes FSM and timer
ped_req  in  1  pedestrian button, level, sampled every cycle
ew_car  in  1  EW vehicle sensor, level
ns_light  out  3  {red,yellow,green}, one-hot
ew_light  out  3  {red,yellow,green}, one-hot
walk  out  1  pedestrian walk lamp
ped_pending  out  1  latched pedestrian request
phase  out  3  current state encoding, for debug

Behaviour:
- Reset (async, immediate):
  - state=NS_G, timer=0, ped_pending=0.
  - Outputs: ns_light=001, ew_light=100, walk=0, phase=NS_G.
- States and outputs (Moore, decoded from the state register only):
  - NS_G: ns green, ew red
  - NS_Y: ns yellow, ew red
  - AR1: both red
  - WALK: both red, walk=1
  - EW_G: ns red, ew green
  - EW_Y: ns red, ew yellow
  - AR2: both red
- Define adv = tick & en. "Last tick" means adv=1 while timer == limit-1, where limit is the current state's *_TICKS.
- Transitions, taken on the clock edge of the last tick:
  - NS_G -> NS_Y, only if (ew_car | ped_pending). Otherwise the timer saturates at GREEN_TICKS-1 and the FSM stays in NS_G. Once saturated, the exit is taken on the first adv cycle with demand.
  - NS_Y -> AR1.
  - AR1 -> WALK if ped_pending, else EW_G.
  - WALK -> EW_G if ew_car, else NS_G.
  - EW_G -> EW_Y. The dwell is always GREEN_TICKS and ignores ew_car.
  - EW_Y -> AR2.
  - AR2 -> NS_G.
- Dwell: each non-NS_G state lasts exactly limit adv-cycles. The state register updates on the edge that samples the last tick, so there is 1 clock of latency from that strobe.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments on adv.
  - Never wraps: saturates at limit-1.
  - Width CNT_W, unsigned. Compare is equality against limit-1, computed in CNT_W bits.
- ped_pending:
  - Set on any cycle where ped_req=1 and state != WALK.
  - Cleared on the edge entering WALK. Clear wins over a simultaneous set.
  - ped_req during WALK is ignored.
  - Captures even when en=0.
- en=0: state and timer hold; tick is ignored; outputs are stable.
- tick coincident with a state change: the new state's timer starts at 0, and that tick is not credited to the new state.
- Illegal or unused state encodings recover to NS_G on the next clock.

Decomposition:
- stoplight_pkg:
  - state_t enum (NS_G, NS_Y, AR1, WALK, EW_G, EW_Y, AR2).
  - Light constants: LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001.
- Sub-module phase_timer:
  - Inputs: clk, rst, clear, enable, limit[CNT_W-1:0].
  - Output: done, meaning enable & count==limit-1.
  - Behaviour: saturating counter.
- The controller instantiates phase_timer once and muxes limit by state.

Test Plan:
All scenarios use GREEN_TICKS=4, YELLOW_TICKS=2, ALLRED_TICKS=1, WALK_TICKS=3, tick=1 every cycle and en=1, unless stated otherwise.
1. Reset, then ew_car=0 and ped_req=0 for 100 cycles -> ns_light=001 and ew_light=100 throughout, phase=NS_G, walk=0.
2. ew_car=1 held from reset -> NS_G 4, NS_Y 2, AR1 1, EW_G 4, EW_Y 2, AR2 1 cycles, giving a repeating 14-cycle period; ns_light/ew_light are never both non-red.
3. ew_car=0, 1-cycle ped_req pulse at cycle 1 -> ped_pending=1 from cycle 2; then NS_Y 2, AR1 1, WALK 3 with walk=1; ped_pending=0 on WALK entry; returns to NS_G.
4. ew_car=1, en=0 for 10 cycles after the first NS_Y cycle -> phase and timer frozen for those 10 cycles; after en=1, NS_Y lasts exactly 1 more cycle.
5. tick asserted every 5th cycle, ew_car=1 -> NS_Y occupies 10 clocks and AR1 occupies 5 clocks.
6. rst pulsed mid-EW_G, with ped_pending=1 set beforehand -> outputs return to NS green / EW red with no clock edge needed; ped_pending=0 and timer=0; normal sequencing resumes after rst falls.
